// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the instruction fetch stage.
package fetch_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          PC_STEP          = 4;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        OUT
    } fetch_state_t;

    // Bundled fetch-to-decode payload, intended to replace the separate output ports.
    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
    } fetch_out_t;

endpackage

// File: rtl/fetch_stage.sv
// Pipeline front end: owns the PC, issues one imem request at a time, presents the word to decode.
// Optional FETCH_PERF_CNT_EN adds saturating fetched/stall-cycle counters.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                  ARCH_LEN = 32,
    parameter int                  INST_LEN = 32,
    parameter logic [ARCH_LEN-1:0] RESET_PC = ARCH_LEN'(RESET_PC_DEFAULT)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall_fetch,
    input  logic                redirect_valid,
    input  logic [ARCH_LEN-1:0] redirect_pc,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [ARCH_LEN-1:0] imem_req_addr,
    input  logic                imem_rsp_valid,
    input  logic [INST_LEN-1:0] imem_rsp_data,
    output logic                fetch_valid_out,
    output logic [INST_LEN-1:0] inst_fetched_out,
    output logic [ARCH_LEN-1:0] pc_out,
    output logic [ARCH_LEN-1:0] pc_plus4_out
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]         perf_fetched,
    output logic [31:0]         perf_stall_cycles
`endif
);

    localparam logic [ARCH_LEN-1:0] STEP = ARCH_LEN'(PC_STEP);

    fetch_state_t        state, state_next;
    logic [ARCH_LEN-1:0] pc_reg, pc_next;
    logic                drop, drop_next;
    logic                valid_next;
    logic [INST_LEN-1:0] inst_next;
    logic [ARCH_LEN-1:0] pc_out_next, pc_plus4_next;
    logic [ARCH_LEN-1:0] redirect_target;
    logic [ARCH_LEN-1:0] pc_inc;

    assign redirect_target = {redirect_pc[ARCH_LEN-1:2], 2'b00};
    assign pc_inc          = pc_reg + STEP;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
        state_next     = state;
        pc_next        = pc_reg;
        drop_next      = drop;
        valid_next     = fetch_valid_out;
        inst_next      = inst_fetched_out;
        pc_out_next    = pc_out;
        pc_plus4_next  = pc_plus4_out;
        imem_req_valid = 1'b0;
        imem_req_addr  = pc_reg;

        unique case (state)
            REQ: begin
                imem_req_valid = !rst;
                if (redirect_valid) begin
                    pc_next = redirect_target;
                end
                if (imem_req_ready) begin
                    state_next = WAIT;
                    // A request accepted together with a redirect fetches a dead path.
                    drop_next  = redirect_valid;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    if (redirect_valid || drop) begin
                        drop_next  = 1'b0;
                        state_next = REQ;
                        if (redirect_valid) begin
                            pc_next = redirect_target;
                        end
                    end else begin
                        valid_next    = 1'b1;
                        inst_next     = imem_rsp_data;
                        pc_out_next   = pc_reg;
                        pc_plus4_next = pc_inc;
                        pc_next       = pc_inc;
                        state_next    = OUT;
                    end
                end else if (redirect_valid) begin
                    pc_next   = redirect_target;
                    drop_next = 1'b1;
                end
            end
            OUT: begin
                if (redirect_valid) begin
                    valid_next = 1'b0;
                    pc_next    = redirect_target;
                    state_next = REQ;
                end else if (!stall_fetch) begin
                    valid_next = 1'b0;
                    state_next = REQ;
                end
            end
            default: begin
                state_next = REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so all of them update together from pre-edge values.
        if (rst) begin
            state            <= REQ;
            pc_reg           <= RESET_PC;
            drop             <= 1'b0;
            fetch_valid_out  <= 1'b0;
            inst_fetched_out <= '0;
            pc_out           <= '0;
            pc_plus4_out     <= '0;
        end else begin
            state            <= state_next;
            pc_reg           <= pc_next;
            drop             <= drop_next;
            fetch_valid_out  <= valid_next;
            inst_fetched_out <= inst_next;
            pc_out           <= pc_out_next;
            pc_plus4_out     <= pc_plus4_next;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic consumed;
    logic stalled;

    // A redirect kills the presented word, so it does not count as consumed.
    assign consumed = (state == OUT) && !redirect_valid && !stall_fetch;
    assign stalled  = (state == OUT) && stall_fetch;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched      <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (consumed && (perf_fetched != '1)) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (stalled && (perf_stall_cycles != '1)) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed corner cases, then random traffic against a PC-flow model.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_fetch;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        fetch_valid_out;
    logic [31:0] inst_fetched_out;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4_out;

    always #5 clk = ~clk;

    fetch_stage #(
        .ARCH_LEN (32),
        .INST_LEN (32),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stall_fetch      (stall_fetch),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .imem_req_valid   (imem_req_valid),
        .imem_req_ready   (imem_req_ready),
        .imem_req_addr    (imem_req_addr),
        .imem_rsp_valid   (imem_rsp_valid),
        .imem_rsp_data    (imem_rsp_data),
        .fetch_valid_out  (fetch_valid_out),
        .inst_fetched_out (inst_fetched_out),
        .pc_out           (pc_out),
        .pc_plus4_out     (pc_plus4_out)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Program image: every address has a distinct word; address 0 holds addi x1,x0,5.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Memory model: one outstanding request, response after mem_cnt extra cycles.
    bit          mem_pending = 1'b0;
    int          mem_cnt     = 0;
    int          mem_lat_cfg = 0;
    logic [31:0] mem_addr    = '0;

    // Reference model: the PC the next presented instruction must carry.
    bit          model_on   = 1'b0;
    logic [31:0] exp_pc     = RESET_PC;
    int          deliveries = 0;

    logic        p_rst, p_stall, p_redir, p_req_valid, p_ready, p_valid;
    logic [31:0] p_redir_pc, p_req_addr;
    logic [31:0] snap_inst, snap_pc, snap_p4;

    task automatic step();
        bit hold;
        @(negedge clk);
        p_rst       = rst;
        p_stall     = stall_fetch;
        p_redir     = redirect_valid;
        p_redir_pc  = redirect_pc;
        p_req_valid = imem_req_valid;
        p_req_addr  = imem_req_addr;
        p_ready     = imem_req_ready;
        p_valid     = fetch_valid_out;
        snap_inst   = inst_fetched_out;
        snap_pc     = pc_out;
        snap_p4     = pc_plus4_out;
        @(posedge clk);
        #1;

        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        if (p_req_valid && p_ready) begin
            if (model_on) check("one_outstanding", 32'(mem_pending), 0);
            mem_pending = 1'b1;
            mem_addr    = p_req_addr;
            mem_cnt     = (mem_lat_cfg < 0) ? int'($urandom_range(2, 0)) : mem_lat_cfg;
        end else if (mem_pending && mem_cnt > 0) begin
            mem_cnt--;
        end
        if (mem_pending && mem_cnt == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mem_addr);
            mem_pending    = 1'b0;
        end

        if (p_rst) begin
            model_on = 1'b1;
            exp_pc   = RESET_PC;
        end else if (p_redir) begin
            exp_pc = {p_redir_pc[31:2], 2'b00};
        end

        if (model_on) begin
            check("req_excl_out", 32'(imem_req_valid & fetch_valid_out), 0);
            hold = p_valid && p_stall && !p_redir && !p_rst;
            if (p_rst) begin
                check("rst_valid", 32'(fetch_valid_out), 0);
            end else if (hold) begin
                check("hold_valid", 32'(fetch_valid_out), 1);
                check("hold_inst", inst_fetched_out, snap_inst);
                check("hold_pc", pc_out, snap_pc);
                check("hold_p4", pc_plus4_out, snap_p4);
            end else if (fetch_valid_out) begin
                check("deliv_pc", pc_out, exp_pc);
                check("deliv_inst", inst_fetched_out, mem_word(exp_pc));
                check("deliv_p4", pc_plus4_out, exp_pc + 32'd4);
                exp_pc = exp_pc + 32'd4;
                deliveries++;
            end
        end
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 60; i++) begin
            if (fetch_valid_out) return;
            step();
        end
        check({tag, "_timeout"}, 32'(fetch_valid_out), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] s_inst, s_pc, s_p4;
        int          del_start;

        rst            = 1'b1;
        stall_fetch    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;

        // Reset values
        step();
        step();
        check("rst_req_valid", 32'(imem_req_valid), 0);
        check("rst_fetch_valid", 32'(fetch_valid_out), 0);
        check("rst_inst", inst_fetched_out, 0);
        check("rst_pc", pc_out, 0);
        check("rst_p4", pc_plus4_out, 0);

        // Zero-wait latency from reset release
        rst = 1'b0;
        #1;
        check("c1_req_valid", 32'(imem_req_valid), 1);
        check("c1_req_addr", imem_req_addr, RESET_PC);
        step();
        step();
        check("lat_valid", 32'(fetch_valid_out), 1);
        check("lat_inst", inst_fetched_out, 32'h0050_0093);
        check("lat_pc", pc_out, 32'h0);
        check("lat_p4", pc_plus4_out, 32'h4);
        step();
        check("next_req_valid", 32'(imem_req_valid), 1);
        check("next_req_addr", imem_req_addr, 32'h4);

        // Stall for 5 cycles in OUT
        wait_valid("stall");
        stall_fetch = 1'b1;
        s_inst = inst_fetched_out;
        s_pc   = pc_out;
        s_p4   = pc_plus4_out;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_valid", 32'(fetch_valid_out), 1);
            check("stall_inst", inst_fetched_out, s_inst);
            check("stall_pc", pc_out, s_pc);
            check("stall_p4", pc_plus4_out, s_p4);
            check("stall_no_req", 32'(imem_req_valid), 0);
        end
        stall_fetch = 1'b0;
        step();
        check("stall_rel_req", 32'(imem_req_valid), 1);
        check("stall_rel_addr", imem_req_addr, s_pc + 32'd4);

        // Redirect while waiting; the response two cycles later is dropped
        mem_lat_cfg = 2;
        step();
        check("wait_no_req", 32'(imem_req_valid), 0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (imem_req_valid) break;
            check("redir_wait_valid", 32'(fetch_valid_out), 0);
            step();
        end
        check("redir_wait_req", 32'(imem_req_valid), 1);
        check("redir_wait_addr", imem_req_addr, 32'h100);
        mem_lat_cfg = 0;

        // Redirect to an unaligned target while stalled in OUT
        wait_valid("redir_out");
        stall_fetch    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        step();
        redirect_valid = 1'b0;
        stall_fetch    = 1'b0;
        check("redir_out_valid", 32'(fetch_valid_out), 0);
        check("redir_out_req", 32'(imem_req_valid), 1);
        check("redir_out_addr", imem_req_addr, 32'h200);

        // PC wrap at the top of the address space
        wait_valid("wrap_pre");
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        wait_valid("wrap");
        check("wrap_pc", pc_out, 32'hFFFF_FFFC);
        check("wrap_p4", pc_plus4_out, 32'h0);
        step();
        check("wrap_next_addr", imem_req_addr, 32'h0);

        // Reset with a request outstanding; the stale response must be ignored
        wait_valid("rst_pre");
        step();
        mem_lat_cfg = 2;
        step();
        check("rst_pre_wait", 32'(imem_req_valid), 0);
        rst = 1'b1;
        step();
        check("rst_wait_valid", 32'(fetch_valid_out), 0);
        check("rst_wait_req", 32'(imem_req_valid), 0);
        rst            = 1'b0;
        imem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("stale_valid", 32'(fetch_valid_out), 0);
            check("stale_req", 32'(imem_req_valid), 1);
            check("stale_addr", imem_req_addr, RESET_PC);
        end
        imem_req_ready = 1'b1;
        mem_lat_cfg    = 0;
        wait_valid("post_rst");
        check("post_rst_pc", pc_out, RESET_PC);
        check("post_rst_inst", inst_fetched_out, 32'h0050_0093);

        // Random traffic against the reference model
        mem_lat_cfg = -1;
        del_start   = deliveries;
        for (int i = 0; i < 3000; i++) begin
            imem_req_ready = ($urandom_range(9, 0) < 7);
            stall_fetch    = ($urandom_range(9, 0) < 3);
            redirect_valid = ($urandom_range(99, 0) < 8);
            redirect_pc    = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0)))
                                                         : 32'($urandom);
            step();
        end
        check("rand_progress", 32'((deliveries - del_start) >= 100), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
